// File: rtl/mips_cpu_hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with sign fix-up.
module mips_cpu_hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_MULU = 5'd22;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_DIVU = 5'd23;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic                   is_div_q, is_signed_q, sign_q, rsign_q, divz_q;
  logic [WIDTH-1:0]       a_q, b_q, m_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic                   op_valid, accept;
  logic [WIDTH:0]         mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0]     step_nxt;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return neg_w(x, sgn & x[WIDTH-1]);
  endfunction

  assign op_valid = (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  assign accept   = (state == IDLE) && start && op_valid;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt_q == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: multiply shifts the product right, divide shifts the remainder left.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, m_q};
    if (is_div_q)
      step_nxt = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      step_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_q      <= 1'b0;
      rsign_q     <= 1'b0;
      divz_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div_q    <= (op == OP_DIV) || (op == OP_DIVU);
            is_signed_q <= (op == OP_MUL) || (op == OP_DIV);
            divz_q      <= (b == '0);
            a_q         <= a;
            b_q         <= b;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        PREP: begin
          sign_q  <= is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rsign_q <= is_signed_q & a_q[WIDTH-1];
          cnt_q   <= '0;
          if (is_div_q) begin
            acc_q <= {{WIDTH{1'b0}}, mag(a_q, is_signed_q)};
            m_q   <= mag(b_q, is_signed_q);
          end else begin
            acc_q <= {{WIDTH{1'b0}}, mag(b_q, is_signed_q)};
            m_q   <= mag(a_q, is_signed_q);
          end
        end
        ITER: begin
          acc_q <= step_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div_q) begin
            {hi, lo} <= neg_2w(acc_q, sign_q);
          end else if (divz_q) begin
            hi <= a_q;
            lo <= '1;
          end else begin
            hi <= neg_w(acc_q[2*WIDTH-1:WIDTH], rsign_q);
            lo <= neg_w(acc_q[WIDTH-1:0], sign_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Bench for mips_cpu_hilo_muldiv: fixed vectors, directed corner sequences and
// random operations checked against an arithmetic reference model.
module tb_mips_cpu_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t tbl[$];

  mips_cpu_hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the MIPS HI/LO rules.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, r;
    longint unsigned ux, uy, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    h = '0;
    l = '0;
    case (o)
      5'd2:  begin r = sx * sy; {h, l} = r; end
      5'd22: begin ur = ux * uy; {h, l} = ur; end
      5'd3, 5'd23: begin
        if (y == 32'h0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else if (o == 5'd3) begin
          r = sx / sy; l = r[31:0];
          r = sx % sy; h = r[31:0];
        end else begin
          ur = ux / uy; l = ur[31:0];
          ur = ux % uy; h = ur[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input bit noise);
    logic [31:0] h0, l0;
    int cyc, bcnt;
    bit hold_ok;
    h0 = hi;
    l0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bcnt = 0; hold_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (noise) begin
        a = $urandom; b = $urandom;
        mthi = 1'($urandom_range(0, 1));
        mtlo = 1'($urandom_range(0, 1));
        start = (cyc == 10) ? 1'b1 : 1'($urandom_range(0, 1));
        op = ($urandom_range(0, 1) == 0) ? 5'd2 : 5'd23;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("latency", 64'(cyc), 64'd34);
    chk("busy_cycles", 64'(bcnt), 64'd34);
    chk("hold_while_busy", 64'(hold_ok), 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk($sformatf("hi op%0d %h,%h", o, x, y), 64'(hi), 64'(eh));
    chk($sformatf("lo op%0d %h,%h", o, x, y), 64'(lo), 64'(el));
  endtask

  task automatic settle();
    @(posedge clk); #1;
    chk("done_single", 64'(done), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el, h0, l0, x, y;
    logic [4:0]  o;
    logic [4:0]  ops [4] = '{5'd2, 5'd22, 5'd3, 5'd23};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{5'd2,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    tbl.push_back('{5'd22, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE});
    tbl.push_back('{5'd3,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back('{5'd23, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF});
    tbl.push_back('{5'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    tbl.push_back('{5'd3,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    tbl.push_back('{5'd3,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    tbl.push_back('{5'd2,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    tbl.push_back('{5'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{5'd23, 32'd9,         32'd4,         32'd1,         32'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, 1'b0);
      settle();
    end

    // Moves to HI/LO while idle
    a = 32'h1234_5678; mthi = 1'b1; l0 = lo;
    @(posedge clk); #1; mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo_kept", 64'(lo), 64'(l0));
    chk("mthi_no_done", 64'(done), 64'd0);
    a = 32'hCAFE_F00D; mtlo = 1'b1;
    @(posedge clk); #1; mtlo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
    a = 32'h0BAD_BEEF; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'h0BAD_BEEF);
    chk("mthilo_lo", 64'(lo), 64'h0BAD_BEEF);

    // Unknown op with start is ignored
    h0 = hi; l0 = lo;
    start = 1'b1; op = 5'd4; a = 32'd5; b = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    chk("badop_busy", 64'(busy), 64'd0);
    chk("badop_hi", 64'(hi), 64'(h0));
    @(posedge clk); #1;
    chk("badop_done", 64'(done), 64'd0);

    // start wins over a same-cycle move; move held during busy is ignored too
    mthi = 1'b1;
    model(5'd2, 32'h0001_0003, 32'hFFFF_FFFD, eh, el);
    do_op(5'd2, 32'h0001_0003, 32'hFFFF_FFFD, eh, el, 1'b0);
    settle();

    // Noisy inputs (moves, restarts) during a DIVU
    model(5'd23, 32'hDEAD_BEEF, 32'h0000_1234, eh, el);
    do_op(5'd23, 32'hDEAD_BEEF, 32'h0000_1234, eh, el, 1'b1);
    settle();

    // Back-to-back: second start in the done cycle
    model(5'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, eh, el);
    do_op(5'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, eh, el, 1'b0);
    model(5'd3, 32'h8000_0001, 32'h0000_0010, eh, el);
    do_op(5'd3, 32'h8000_0001, 32'h0000_0010, eh, el, 1'b0);
    settle();

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 3)];
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 7));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      model(o, x, y, eh, el);
      do_op(o, x, y, eh, el, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) settle();
    end
    settle();

    // Asynchronous reset in the middle of a MULT
    start = 1'b1; op = 5'd2; a = 32'h0000_1111; b = 32'h0000_2222;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_done", 64'(done), 64'd0);
    chk("areset_hi", 64'(hi), 64'd0);
    chk("areset_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    chk("areset_held_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(5'd23, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
